// File: rtl/cnn_layer_accel_pkg.sv
// Shared state encoding and sizing helpers for the CE front end.
package cnn_layer_accel_pkg;

   typedef enum logic [5:0] {
      ST_IDLE               = 6'b000001,
      ST_AWE_CE_PRIM_BUFFER = 6'b000010,
      ST_WAIT_PFB_LOAD      = 6'b000100,
      ST_AWE_CE_ACTIVE      = 6'b001000,
      ST_WAIT_JOB_DONE      = 6'b010000,
      ST_SEND_COMPLETE      = 6'b100000
   } seq_state_t;

   localparam int C_DEF_PIXEL_WIDTH = 16;
   localparam int C_DEF_MAX_COLS    = 512;

   function automatic int cw_of(input int max_cols);
      return $clog2(max_cols);
   endfunction

endpackage

// File: rtl/cnn_layer_accel_pfb_row_sequencer.sv
// Row-by-row job sequencer feeding the CE prefetch buffer:
// fetches each source row into the PFB, then streams it out by column.
module cnn_layer_accel_pfb_row_sequencer
   import cnn_layer_accel_pkg::*;
#(
   parameter int  C_PIXEL_WIDTH = C_DEF_PIXEL_WIDTH,
   parameter int  C_MAX_COLS    = C_DEF_MAX_COLS,
   localparam int C_CW          = cw_of(C_MAX_COLS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     job_start,
   input  logic [C_CW-1:0]          num_cols,
   input  logic [C_CW-1:0]          num_rows,
   input  logic [C_CW-1:0]          src_cols,
   output logic                     fetch_req,
   output logic [C_CW-1:0]          fetch_row,
   input  logic                     fetch_gnt,
   input  logic [C_PIXEL_WIDTH-1:0] mem_dout,
   input  logic                     mem_dout_vld,
   output logic [C_PIXEL_WIDTH-1:0] pfb_din,
   output logic                     pfb_wr_en,
   output logic                     pfb_rd_en,
   input  logic                     ce_rdy,
   output logic [C_CW-1:0]          input_row,
   output logic [C_CW-1:0]          input_col,
   output logic                     next_row,
   output logic                     rst_addr,
   output logic                     job_fetch_ack,
   input  logic                     cncl_fetch_req,
   input  logic                     ce_done,
   output logic                     job_complete_ack,
   output logic [5:0]               state
);

   seq_state_t      cur;
   seq_state_t      nxt;
   logic            entry;
   logic            load_done;
   logic            wr_gate;
   logic [C_CW-1:0] wr_cnt;

   assign state = cur;

   // Words are only accepted while a granted fetch is in flight.
   assign wr_gate = (cur == ST_WAIT_PFB_LOAD && !load_done)
                  || (fetch_req && fetch_gnt);

   always_comb begin
      nxt              = cur;
      fetch_req        = 1'b0;
      job_fetch_ack    = 1'b0;
      rst_addr         = 1'b0;
      pfb_rd_en        = 1'b0;
      next_row         = 1'b0;
      job_complete_ack = 1'b0;
      load_done        = 1'b0;
      unique case (cur)
         ST_IDLE: begin
            if (job_start)
               nxt = ST_AWE_CE_PRIM_BUFFER;
         end
         ST_AWE_CE_PRIM_BUFFER: begin
            if (entry) begin
               job_fetch_ack = 1'b1;
               if (cncl_fetch_req)
                  nxt = ST_AWE_CE_ACTIVE;
            end else begin
               fetch_req = 1'b1;
               if (fetch_gnt)
                  nxt = ST_WAIT_PFB_LOAD;
            end
         end
         ST_WAIT_PFB_LOAD: begin
            if (pfb_wr_en && wr_cnt == src_cols) begin
               load_done = 1'b1;
               nxt       = ST_AWE_CE_ACTIVE;
            end
         end
         ST_AWE_CE_ACTIVE: begin
            if (entry) begin
               rst_addr = 1'b1;
            end else begin
               pfb_rd_en = ce_rdy;
               if (ce_rdy && input_col == num_cols) begin
                  next_row = 1'b1;
                  if (input_row == num_rows)
                     nxt = ST_WAIT_JOB_DONE;
                  else
                     nxt = ST_AWE_CE_PRIM_BUFFER;
               end
            end
         end
         ST_WAIT_JOB_DONE: begin
            if (ce_done)
               nxt = ST_SEND_COMPLETE;
         end
         ST_SEND_COMPLETE: begin
            job_complete_ack = 1'b1;
            nxt              = ST_IDLE;
         end
         default: nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur       <= ST_IDLE;
         entry     <= 1'b0;
         wr_cnt    <= '0;
         fetch_row <= '0;
         input_row <= '0;
         input_col <= '0;
         pfb_din   <= '0;
         pfb_wr_en <= 1'b0;
      end else begin
         cur       <= nxt;
         entry     <= (nxt != cur);
         pfb_din   <= mem_dout;
         pfb_wr_en <= mem_dout_vld && wr_gate;
         if (fetch_req && fetch_gnt)
            wr_cnt <= '0;
         else if (cur == ST_WAIT_PFB_LOAD && pfb_wr_en)
            wr_cnt <= wr_cnt + 1'b1;
         if (cur == ST_IDLE) begin
            fetch_row <= '0;
            input_row <= '0;
            input_col <= '0;
         end else begin
            if (load_done && fetch_row != num_rows)
               fetch_row <= fetch_row + 1'b1;
            if (pfb_rd_en)
               input_col <= next_row ? {C_CW{1'b0}}
                                     : input_col + 1'b1;
            if (next_row && input_row != num_rows)
               input_row <= input_row + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cnn_layer_accel_pfb_row_sequencer.sv
// Directed bench for the PFB row sequencer with a simple memory model.
module tb_cnn_layer_accel_pfb_row_sequencer;

   logic        clk;
   logic        rst;
   logic        job_start;
   logic [8:0]  num_cols;
   logic [8:0]  num_rows;
   logic [8:0]  src_cols;
   logic        fetch_req;
   logic [8:0]  fetch_row;
   logic        fetch_gnt;
   logic [15:0] mem_dout;
   logic        mem_dout_vld;
   logic [15:0] pfb_din;
   logic        pfb_wr_en;
   logic        pfb_rd_en;
   logic        ce_rdy;
   logic [8:0]  input_row;
   logic [8:0]  input_col;
   logic        next_row;
   logic        rst_addr;
   logic        job_fetch_ack;
   logic        cncl_fetch_req;
   logic        ce_done;
   logic        job_complete_ack;
   logic [5:0]  state;

   logic        r_vld;
   logic [15:0] r_dout;
   logic        t_vld;
   logic [15:0] t_dout;
   logic [3:0]  cncl_mask;

   int checks   = 0;
   int failures = 0;

   int n_gnt  = 0;
   int n_wr   = 0;
   int n_rd   = 0;
   int n_next = 0;
   int n_ack  = 0;
   int n_jfa  = 0;
   int n_rsta = 0;
   logic [8:0] fr_log [0:15];

   assign mem_dout_vld   = r_vld | t_vld;
   assign mem_dout       = t_vld ? t_dout : r_dout;
   assign cncl_fetch_req = cncl_mask[input_row[1:0]];

   cnn_layer_accel_pfb_row_sequencer dut (
      .clk              (clk),
      .rst              (rst),
      .job_start        (job_start),
      .num_cols         (num_cols),
      .num_rows         (num_rows),
      .src_cols         (src_cols),
      .fetch_req        (fetch_req),
      .fetch_row        (fetch_row),
      .fetch_gnt        (fetch_gnt),
      .mem_dout         (mem_dout),
      .mem_dout_vld     (mem_dout_vld),
      .pfb_din          (pfb_din),
      .pfb_wr_en        (pfb_wr_en),
      .pfb_rd_en        (pfb_rd_en),
      .ce_rdy           (ce_rdy),
      .input_row        (input_row),
      .input_col        (input_col),
      .next_row         (next_row),
      .rst_addr         (rst_addr),
      .job_fetch_ack    (job_fetch_ack),
      .cncl_fetch_req   (cncl_fetch_req),
      .ce_done          (ce_done),
      .job_complete_ack (job_complete_ack),
      .state            (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: grant two clocks after a request, then stream the row.
   initial begin
      fetch_gnt = 1'b0;
      r_vld     = 1'b0;
      r_dout    = 16'h0;
      forever begin
         @(posedge clk); #1;
         if (fetch_req && !rst) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            fetch_gnt = 1'b1;
            @(posedge clk); #1;
            fetch_gnt = 1'b0;
            for (int i = 0; i <= int'(src_cols); i++) begin
               r_dout = 16'(16'hA000 + i);
               r_vld  = 1'b1;
               @(posedge clk); #1;
            end
            r_vld = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (fetch_req && fetch_gnt) begin
         fr_log[n_gnt % 16] = fetch_row;
         n_gnt++;
      end
      if (pfb_wr_en) n_wr++;
      if (pfb_rd_en) n_rd++;
      if (next_row) n_next++;
      if (job_complete_ack) n_ack++;
      if (job_fetch_ack) n_jfa++;
      if (rst_addr) n_rsta++;
   end

   task automatic pulse_start();
      @(posedge clk); #1 job_start = 1'b1;
      @(posedge clk); #1 job_start = 1'b0;
   endtask

   task automatic run_job(input logic [8:0] c, input logic [8:0] r,
                          input logic [8:0] s, output bit ok);
      num_cols = c;
      num_rows = r;
      src_cols = s;
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (job_complete_ack) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (state !== 6'b000001) begin
         failures++;
         $display("FAIL reset_state got=%b exp=000001", state);
      end
      checks++;
      if ({fetch_req, pfb_wr_en, pfb_rd_en, next_row, rst_addr,
           job_fetch_ack, job_complete_ack} !== 7'b0) begin
         failures++;
         $display("FAIL reset_strobes got=%b%b%b%b%b%b%b exp=0",
                  fetch_req, pfb_wr_en, pfb_rd_en, next_row,
                  rst_addr, job_fetch_ack, job_complete_ack);
      end
      checks++;
      if ({input_row, input_col, fetch_row} !== 27'd0 ||
          pfb_din !== 16'h0) begin
         failures++;
         $display("FAIL reset_counters row=%0d col=%0d frow=%0d din=%h exp=0",
                  input_row, input_col, fetch_row, pfb_din);
      end
      rst = 1'b0;
   endtask

   task automatic test_wr_gate();
      @(posedge clk); #1;
      t_dout = 16'h1234;
      t_vld  = 1'b1;
      @(negedge clk);
      checks++;
      if (pfb_din === 16'h1234) begin
         failures++;
         $display("FAIL din_early got=%h exp=previous value", pfb_din);
      end
      @(posedge clk); #1 t_dout = 16'hBEEF;
      @(negedge clk);
      checks++;
      if (pfb_din !== 16'h1234 || pfb_wr_en !== 1'b0) begin
         failures++;
         $display("FAIL din_lat1 din=%h wr=%b exp din=1234 wr=0",
                  pfb_din, pfb_wr_en);
      end
      @(posedge clk); #1 t_vld = 1'b0;
      @(negedge clk);
      checks++;
      if (pfb_din !== 16'hBEEF || pfb_wr_en !== 1'b0 ||
          state !== 6'b000001) begin
         failures++;
         $display("FAIL din_lat2 din=%h wr=%b st=%b exp BEEF/0/000001",
                  pfb_din, pfb_wr_en, state);
      end
   endtask

   task automatic test_basic();
      int g0, w0, r0, nx0, a0, j0, ra0;
      bit seen;
      g0 = n_gnt; w0 = n_wr; r0 = n_rd; nx0 = n_next;
      a0 = n_ack; j0 = n_jfa; ra0 = n_rsta;
      ce_done  = 1'b0;
      num_cols = 9'd3;
      num_rows = 9'd1;
      src_cols = 9'd3;
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (state === 6'b010000) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL basic_reach_done got=timeout exp=WAIT_JOB_DONE");
      end
      checks++;
      if (fetch_row !== 9'd1 || input_row !== 9'd1 ||
          input_col !== 9'd0) begin
         failures++;
         $display("FAIL basic_sat frow=%0d row=%0d col=%0d exp=1/1/0",
                  fetch_row, input_row, input_col);
      end
      ce_done = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (n_gnt - g0 != 2 || fr_log[g0 % 16] !== 9'd0 ||
          fr_log[(g0 + 1) % 16] !== 9'd1) begin
         failures++;
         $display("FAIL basic_fetch n=%0d rows=%0d,%0d exp 2 rows 0,1",
                  n_gnt - g0, fr_log[g0 % 16], fr_log[(g0 + 1) % 16]);
      end
      checks++;
      if (n_wr - w0 != 8 || n_rd - r0 != 8) begin
         failures++;
         $display("FAIL basic_wr_rd wr=%0d rd=%0d exp 8/8",
                  n_wr - w0, n_rd - r0);
      end
      checks++;
      if (n_next - nx0 != 2 || n_ack - a0 != 1 ||
          n_jfa - j0 != 2 || n_rsta - ra0 != 2) begin
         failures++;
         $display("FAIL basic_pulses nr=%0d ack=%0d jfa=%0d ra=%0d exp 2/1/2/2",
                  n_next - nx0, n_ack - a0, n_jfa - j0, n_rsta - ra0);
      end
      checks++;
      if (state !== 6'b000001) begin
         failures++;
         $display("FAIL basic_idle got=%b exp=000001", state);
      end
   endtask

   task automatic test_cncl();
      int g0, w0, r0, nx0, a0, j0;
      bit ok;
      g0 = n_gnt; w0 = n_wr; r0 = n_rd; nx0 = n_next;
      a0 = n_ack; j0 = n_jfa;
      cncl_mask = 4'b1001;
      run_job(9'd1, 9'd3, 9'd1, ok);
      cncl_mask = 4'b0000;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL cncl_done got=timeout exp=ack");
      end
      checks++;
      if (n_gnt - g0 != 2 || fr_log[g0 % 16] !== 9'd0 ||
          fr_log[(g0 + 1) % 16] !== 9'd1) begin
         failures++;
         $display("FAIL cncl_fetch n=%0d rows=%0d,%0d exp 2 rows 0,1",
                  n_gnt - g0, fr_log[g0 % 16], fr_log[(g0 + 1) % 16]);
      end
      checks++;
      if (n_wr - w0 != 4 || n_rd - r0 != 8 || n_next - nx0 != 4) begin
         failures++;
         $display("FAIL cncl_counts wr=%0d rd=%0d nr=%0d exp 4/8/4",
                  n_wr - w0, n_rd - r0, n_next - nx0);
      end
      checks++;
      if (n_jfa - j0 != 4 || n_ack - a0 != 1) begin
         failures++;
         $display("FAIL cncl_pulses jfa=%0d ack=%0d exp 4/1",
                  n_jfa - j0, n_ack - a0);
      end
   endtask

   task automatic test_stall();
      int r0, nx0, exp_col, bad_col, bad_nr;
      bit done;
      r0 = n_rd; nx0 = n_next;
      exp_col = 0; bad_col = 0; bad_nr = 0;
      num_cols = 9'd7;
      num_rows = 9'd0;
      src_cols = 9'd7;
      pulse_start();
      done = 1'b0;
      for (int c = 0; c < 600 && !done; c++) begin
         @(posedge clk); #1 ce_rdy = c[0];
         @(negedge clk);
         if (job_complete_ack) done = 1'b1;
         if (state === 6'b001000) begin
            if (input_col !== 9'(exp_col)) bad_col++;
            if (pfb_rd_en) begin
               if (next_row !== (exp_col == 7)) bad_nr++;
               exp_col++;
            end else if (next_row !== 1'b0) begin
               bad_nr++;
            end
         end
      end
      ce_rdy = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL stall_done got=timeout exp=ack");
      end
      checks++;
      if (bad_col != 0) begin
         failures++;
         $display("FAIL stall_col_hold got=%0d bad cycles exp=0", bad_col);
      end
      checks++;
      if (bad_nr != 0 || n_next - nx0 != 1) begin
         failures++;
         $display("FAIL stall_next_row bad=%0d n=%0d exp 0/1",
                  bad_nr, n_next - nx0);
      end
      checks++;
      if (n_rd - r0 != 8) begin
         failures++;
         $display("FAIL stall_rd got=%0d exp=8", n_rd - r0);
      end
   endtask

   task automatic test_start_ignored();
      int g0, r0, a0;
      bit seen, ok;
      g0 = n_gnt; r0 = n_rd; a0 = n_ack;
      num_cols = 9'd3;
      num_rows = 9'd1;
      src_cols = 9'd3;
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (state === 6'b001000) begin
            seen = 1'b1;
            break;
         end
      end
      @(posedge clk); #1 job_start = 1'b1;
      @(posedge clk); #1 job_start = 1'b0;
      @(negedge clk);
      checks++;
      if (!seen || state !== 6'b001000 || input_row !== 9'd0) begin
         failures++;
         $display("FAIL start_ign_active seen=%b st=%b row=%0d exp 1/001000/0",
                  seen, state, input_row);
      end
      ok = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (job_complete_ack) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (6) @(negedge clk);
      checks++;
      if (!ok || n_rd - r0 != 8 || n_gnt - g0 != 2 || n_ack - a0 != 1) begin
         failures++;
         $display("FAIL start_ign_job ok=%b rd=%0d gnt=%0d ack=%0d exp 1/8/2/1",
                  ok, n_rd - r0, n_gnt - g0, n_ack - a0);
      end
      checks++;
      if (state !== 6'b000001) begin
         failures++;
         $display("FAIL start_ign_idle got=%b exp=000001", state);
      end
   endtask

   task automatic test_rst_mid();
      int w0, g0, r0, a0, wm;
      bit seen, ok;
      w0 = n_wr;
      num_cols = 9'd3;
      num_rows = 9'd1;
      src_cols = 9'd3;
      pulse_start();
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (state === 6'b000100 && n_wr - w0 >= 2) begin
            seen = 1'b1;
            break;
         end
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (!seen || state !== 6'b000001) begin
         failures++;
         $display("FAIL rst_mid_state seen=%b got=%b exp=000001", seen, state);
      end
      checks++;
      if ({fetch_req, pfb_wr_en, pfb_rd_en, next_row, rst_addr,
           job_fetch_ack, job_complete_ack} !== 7'b0 ||
          {input_row, input_col, fetch_row} !== 27'd0 ||
          pfb_din !== 16'h0) begin
         failures++;
         $display("FAIL rst_mid_outputs req=%b wr=%b rd=%b row=%0d col=%0d frow=%0d din=%h exp all 0",
                  fetch_req, pfb_wr_en, pfb_rd_en, input_row,
                  input_col, fetch_row, pfb_din);
      end
      rst = 1'b0;
      wm = n_wr;
      repeat (12) @(negedge clk);
      checks++;
      if (n_wr != wm) begin
         failures++;
         $display("FAIL rst_mid_drop got=%0d writes exp=0", n_wr - wm);
      end
      g0 = n_gnt; w0 = n_wr; r0 = n_rd; a0 = n_ack;
      run_job(9'd3, 9'd1, 9'd3, ok);
      checks++;
      if (!ok || n_gnt - g0 != 2 || n_wr - w0 != 8 ||
          n_rd - r0 != 8 || n_ack - a0 != 1) begin
         failures++;
         $display("FAIL rst_mid_rerun ok=%b gnt=%0d wr=%0d rd=%0d ack=%0d exp 1/2/8/8/1",
                  ok, n_gnt - g0, n_wr - w0, n_rd - r0, n_ack - a0);
      end
   endtask

   initial begin
      rst       = 1'b1;
      job_start = 1'b0;
      num_cols  = 9'd0;
      num_rows  = 9'd0;
      src_cols  = 9'd0;
      ce_rdy    = 1'b1;
      ce_done   = 1'b1;
      t_vld     = 1'b0;
      t_dout    = 16'h0;
      cncl_mask = 4'b0000;
      test_reset();
      test_wr_gate();
      test_basic();
      test_cncl();
      test_stall();
      test_start_ignored();
      test_rst_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
